// File: rtl/regfile_weight3_loader_if.sv
// rtl/regfile_weight3_loader_if.sv - weight word stream into the weight-3 loader
interface regfile_weight3_loader_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/regfile_weight3_loader.sv
// rtl/regfile_weight3_loader.sv - run-time loader for the weight-3 register file
module regfile_weight3_loader #(
  parameter int DW    = 16,
  parameter int AW    = 14,
  parameter int DEPTH = 16384
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  regfile_weight3_loader_if.slave wr,
  output logic                   busy,
  output logic                   done,
  output logic [AW:0]            words_loaded,
  output logic [DW-1:0]          checksum,
  input  logic [AW-1:0]          ra1,
  output logic [DW-1:0]          rd1
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [DW-1:0] rf [0:DEPTH-1];
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic          accept;

  assign wr.in_ready = busy;
  assign accept      = wr.in_valid & busy;
  assign widx        = words_loaded[IW-1:0];
  assign ridx        = ra1[IW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            done         <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
          end
        end
        LOAD: begin
          if (wr.in_valid) begin
            words_loaded <= words_loaded + (AW+1)'(1);
            checksum     <= checksum + wr.in_data;
            if (words_loaded == (AW+1)'(DEPTH-1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Array is never cleared; a reset in the same cycle also suppresses the write.
  always_ff @(posedge clk) begin
    if (accept && !reset)
      rf[widx] <= wr.in_data;
  end

  assign rd1 = ({1'b0, ra1} < (AW+1)'(DEPTH)) ? rf[ridx] : '0;
endmodule

// File: tb/tb_regfile_weight3_loader.sv
// tb/tb_regfile_weight3_loader.sv - directed bench for the weight-3 loader
module tb_regfile_weight3_loader;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW:0]   words_loaded;
  logic [DW-1:0] checksum;
  logic [AW-1:0] ra1;
  logic [DW-1:0] rd1;
  logic [DW-1:0] expect_rf [0:DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_weight3_loader_if #(.DW(DW)) bus ();

  regfile_weight3_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .wr           (bus.slave),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded),
    .checksum     (checksum),
    .ra1          (ra1),
    .rd1          (rd1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    expect_rf[words_loaded[2:0]] = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = AW'(i);
      #1;
      check($sformatf("%s rf[%0d]", tag, i), 32'(rd1), 32'(expect_rf[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    ra1 = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1: back-to-back stream
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset words_loaded", 32'(words_loaded), 32'd0);
    check("reset checksum", 32'(checksum), 32'd0);
    pulse_start();
    check("t1 busy", 32'(busy), 32'd1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("t1 in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_data = 16'hA5A0 + 16'(i);
      expect_rf[i] = 16'hA5A0 + 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("t1 done", 32'(done), 32'd1);
    check("t1 in_ready low", 32'(bus.in_ready), 32'd0);
    check("t1 words_loaded", 32'(words_loaded), 32'd8);
    check("t1 checksum", 32'(checksum), 32'h2D1C);
    check_array("t1");

    // 2: valid on alternate cycles
    pulse_start();
    check("t2 done cleared", 32'(done), 32'd0);
    check("t2 words_loaded cleared", 32'(words_loaded), 32'd0);
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = (c % 2 == 0) ? 16'hA5A0 + 16'(c / 2) : 16'h5555;
      if (c == 14) check("t2 busy before last", 32'(busy), 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("t2 done", 32'(done), 32'd1);
    check("t2 words_loaded", 32'(words_loaded), 32'd8);
    check("t2 checksum", 32'(checksum), 32'h2D1C);
    check_array("t2");

    // 3: reset mid-load
    pulse_start();
    for (int i = 0; i < 3; i++) push(16'h1110 + 16'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1113;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("t3 busy", 32'(busy), 32'd0);
    check("t3 in_ready", 32'(bus.in_ready), 32'd0);
    check("t3 words_loaded", 32'(words_loaded), 32'd0);
    check("t3 checksum", 32'(checksum), 32'd0);
    check_array("t3");

    // 4: start ignored in LOAD, honoured in DONE
    pulse_start();
    for (int i = 0; i < 3; i++) push(16'h2220 + 16'(i));
    start = 1'b1;
    push(16'h2223);
    start = 1'b0;
    check("t4 start ignored busy", 32'(busy), 32'd1);
    check("t4 count continues", 32'(words_loaded), 32'd4);
    for (int i = 4; i < DEPTH; i++) push(16'h2220 + 16'(i));
    check("t4 done", 32'(done), 32'd1);
    check("t4 checksum", 32'(checksum), 32'h111C);
    pulse_start();
    check("t4 restart done", 32'(done), 32'd0);
    check("t4 restart words_loaded", 32'(words_loaded), 32'd0);
    check("t4 restart busy", 32'(busy), 32'd1);
    push(16'h3330);
    check_array("t4");

    // 5: checksum wrap-around
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_start();
    push(16'hFFFF);
    push(16'hFFFF);
    for (int i = 0; i < 6; i++) push(16'h0003);
    check("t5 done", 32'(done), 32'd1);
    check("t5 checksum", 32'(checksum), 32'h0010);

    // 6: read-during-write and out-of-range reads
    pulse_start();
    for (int i = 0; i < 4; i++) push(16'h4440 + 16'(i));
    ra1 = 4'd4;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4444;
    #1;
    check("t6 rd1 old word", 32'(rd1), 32'h0003);
    tick();
    bus.in_valid = 1'b0;
    check("t6 rd1 new word", 32'(rd1), 32'h4444);
    ra1 = 4'd9;
    #1;
    check("t6 rd1 addr 9", 32'(rd1), 32'd0);
    ra1 = 4'd8;
    #1;
    check("t6 rd1 addr 8", 32'(rd1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
